// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Shared opcode/state encodings and constants for exec_unit.
// Revision: 1.0
// ============================================================================
package exec_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10,
        ALU_MUL = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int MUL_CYCLES = 16;

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nzp_calc.sv
`default_nettype none
// ============================================================================
// Module  : nzp_calc
// Brief   : Combinational condition-code decode of a 16-bit value ({N,Z,P}).
// Revision: 1.0
// ============================================================================
module nzp_calc (
    input  logic [15:0] i_value,
    output logic [2:0]  o_nzp
);

    always_comb begin
        if (i_value[15])
            o_nzp = 3'b100;
        else if (i_value == 16'h0000)
            o_nzp = 3'b010;
        else
            o_nzp = 3'b001;
    end

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : exec_unit
// Brief   : ADD/AND/NOT in one cycle, 16-step shift-add MUL, registered NZP.
// Revision: 1.0
// ============================================================================
module exec_unit
    import exec_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  ALUK,
    input  logic        SR2MUX,
    input  logic [4:0]  IMM5,
    input  logic [15:0] SR1_OUT,
    input  logic [15:0] SR2_OUT,
    output logic [15:0] Result,
    output logic        Done,
    output logic        Busy,
    output logic [2:0]  NZP
);

    localparam logic [3:0] c_LAST_CNT = 4'(MUL_CYCLES - 1);

    state_e      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_result;
    logic [2:0]  r_nzp;
    logic        r_done;
    logic        r_busy;

    logic [15:0] w_b_sel;
    logic [15:0] w_alu;
    logic [15:0] w_acc_step;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_load;
    logic [15:0] w_load_val;
    logic [2:0]  w_nzp;

    always_comb begin
        w_b_sel    = SR2MUX ? sext5(IMM5) : SR2_OUT;
        w_accept   = Start && (r_state != ST_CALC);
        w_is_mul   = (ALUK == ALU_MUL);
        w_acc_step = r_acc + (r_b[0] ? r_a : 16'h0000);
        case (ALUK)
            ALU_ADD: w_alu = SR1_OUT + w_b_sel;
            ALU_AND: w_alu = SR1_OUT & w_b_sel;
            default: w_alu = ~SR1_OUT;
        endcase
        // Single-cycle ops load at acceptance; MUL loads on its final step.
        w_load     = 1'b0;
        w_load_val = w_alu;
        if (w_accept && !w_is_mul) begin
            w_load = 1'b1;
        end else if (r_state == ST_CALC && r_cnt == c_LAST_CNT) begin
            w_load     = 1'b1;
            w_load_val = w_acc_step;
        end
    end

    nzp_calc u_nzp_calc (
        .i_value (w_load_val),
        .o_nzp   (w_nzp)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_acc    <= 16'h0000;
            r_cnt    <= 4'd0;
            r_result <= 16'h0000;
            r_nzp    <= 3'b010;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
            case (r_state)
                ST_CALC: begin
                    r_acc <= w_acc_step;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_CNT) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_a <= SR1_OUT;
                        r_b <= w_b_sel;
                        if (w_is_mul) begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                            r_acc   <= 16'h0000;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
            if (w_load) begin
                r_result <= w_load_val;
                r_nzp    <= w_nzp;
            end
        end
    end

    assign Result = r_result;
    assign Done   = r_done;
    assign Busy   = r_busy;
    assign NZP    = r_nzp;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_exec_unit
// Brief   : Self-checking bench for exec_unit with a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_exec_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  ALUK = 2'b00;
    logic        SR2MUX = 1'b0;
    logic [4:0]  IMM5 = 5'd0;
    logic [15:0] SR1_OUT = 16'h0;
    logic [15:0] SR2_OUT = 16'h0;
    logic [15:0] Result;
    logic        Done;
    logic        Busy;
    logic [2:0]  NZP;

    int n_checks = 0;
    int n_fail   = 0;

    exec_unit dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .ALUK    (ALUK),
        .SR2MUX  (SR2MUX),
        .IMM5    (IMM5),
        .SR1_OUT (SR1_OUT),
        .SR2_OUT (SR2_OUT),
        .Result  (Result),
        .Done    (Done),
        .Busy    (Busy),
        .NZP     (NZP)
    );

    always #5 Clk = ~Clk;

    // Reference model: completion edge index and pending value per operation.
    int          cyc = 0;
    int          m_done_at = -1;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_res = 16'h0;
    logic [2:0]  m_nzp = 3'b010;
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge Clk) begin
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        cyc = cyc + 1;
        if (!Reset) begin
            m_done_at = -1;
            m_res     = 16'h0;
            m_nzp     = 3'b010;
        end else begin
            if (Start && cyc > m_done_at) begin
                a = SR1_OUT;
                b = SR2MUX ? {{11{IMM5[4]}}, IMM5} : SR2_OUT;
                prod = 32'(a) * 32'(b);
                case (ALUK)
                    2'b00: m_pend = a + b;
                    2'b01: m_pend = a & b;
                    2'b10: m_pend = ~a;
                    default: m_pend = prod[15:0];
                endcase
                m_done_at = (ALUK == 2'b11) ? cyc + 16 : cyc;
            end
            if (cyc == m_done_at) begin
                m_res = m_pend;
                m_nzp = m_res[15] ? 3'b100 : (m_res == 16'h0) ? 3'b010 : 3'b001;
            end
        end
        m_done  = (cyc == m_done_at);
        m_busy  = (m_done_at > cyc);
        m_valid = 1'b1;
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            n_checks = n_checks + 4;
            if (Done !== m_done) begin
                n_fail = n_fail + 1;
                $display("FAIL model_done cyc=%0d actual=%b required=%b", cyc, Done, m_done);
            end
            if (Busy !== m_busy) begin
                n_fail = n_fail + 1;
                $display("FAIL model_busy cyc=%0d actual=%b required=%b", cyc, Busy, m_busy);
            end
            if (Result !== m_res) begin
                n_fail = n_fail + 1;
                $display("FAIL model_result cyc=%0d actual=%h required=%h", cyc, Result, m_res);
            end
            if (NZP !== m_nzp) begin
                n_fail = n_fail + 1;
                $display("FAIL model_nzp cyc=%0d actual=%b required=%b", cyc, NZP, m_nzp);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one Start pulse across one rising edge; returns at edge+2.
    task automatic launch(input logic [1:0] op, input logic mux, input logic [4:0] imm,
                          input logic [15:0] a, input logic [15:0] b);
        ALUK = op; SR2MUX = mux; IMM5 = imm; SR1_OUT = a; SR2_OUT = b; Start = 1'b1;
        @(posedge Clk); #2;
        Start = 1'b0;
    endtask

    task automatic sample;
        @(negedge Clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #2; Start = 1'b1;
        sample();
        chk("reset_result", Result, 16'h0000);
        chk("reset_nzp", 16'(NZP), 16'h0002);
        chk("reset_done_busy", {14'h0, Done, Busy}, 16'h0000);
        @(posedge Clk); #2; Start = 1'b0; Reset = 1'b1;
        repeat (2) @(posedge Clk); #2;

        // ADD with negative immediate: 5 + (-3)
        launch(2'b00, 1'b1, 5'b11101, 16'h0005, 16'h1234);
        sample();
        chk("add_imm_done", 16'(Done), 16'h0001);
        chk("add_imm_result", Result, 16'h0002);
        chk("add_imm_nzp", 16'(NZP), 16'h0001);
        sample();
        chk("done_one_cycle", 16'(Done), 16'h0000);
        chk("result_hold", Result, 16'h0002);

        launch(2'b01, 1'b0, 5'd0, 16'hF0F0, 16'h0F0F);
        sample();
        chk("and_result", Result, 16'h0000);
        chk("and_nzp", 16'(NZP), 16'h0002);
        launch(2'b10, 1'b0, 5'd0, 16'h0000, 16'h5555);
        sample();
        chk("not_result", Result, 16'hFFFF);
        chk("not_nzp", 16'(NZP), 16'h0004);

        // ADD wraparound through SR2_OUT
        launch(2'b00, 1'b0, 5'd0, 16'hFFFF, 16'h0002);
        repeat (2) sample();

        // MUL 7 * -3 with operands scrambled after acceptance
        launch(2'b11, 1'b0, 5'd0, 16'h0007, 16'hFFFD);
        SR1_OUT = 16'hAAAA; SR2_OUT = 16'h5555; ALUK = 2'b00; IMM5 = 5'h1F;
        repeat (15) @(posedge Clk);
        sample();
        chk("mul_busy_last", {14'h0, Done, Busy}, 16'h0001);
        sample();
        chk("mul_done", {14'h0, Done, Busy}, 16'h0002);
        chk("mul_result", Result, 16'hFFEB);
        chk("mul_nzp", 16'(NZP), 16'h0004);
        repeat (2) sample();

        // MUL with ADD Start attempted during CALC
        launch(2'b11, 1'b0, 5'd0, 16'h1234, 16'h0003);
        repeat (4) @(posedge Clk); #2;
        ALUK = 2'b00; SR1_OUT = 16'h0001; SR2_OUT = 16'h0001; Start = 1'b1;
        @(posedge Clk); #2; Start = 1'b0;
        repeat (10) @(posedge Clk);
        sample();
        chk("mul_ignore_pending", 16'(Done), 16'h0000);
        sample();
        chk("mul_ignore_result", Result, 16'h369C);
        sample();
        chk("mul_ignore_no_extra", 16'(Done), 16'h0000);

        // MUL overflow to zero, then signed * signed
        launch(2'b11, 1'b0, 5'd0, 16'h0100, 16'h0100);
        repeat (18) sample();
        launch(2'b11, 1'b1, 5'b10000, 16'hFFFB, 16'h0000);
        repeat (17) sample();
        chk("mul_negneg", Result, 16'h0050);

        // Reset during CALC aborts the multiply
        launch(2'b11, 1'b0, 5'd0, 16'h0003, 16'h0003);
        repeat (7) @(posedge Clk); #2;
        Reset = 1'b0; Start = 1'b1;
        @(posedge Clk); #2;
        Reset = 1'b1; Start = 1'b0;
        sample();
        chk("abort_result", Result, 16'h0000);
        chk("abort_nzp", 16'(NZP), 16'h0002);
        chk("abort_flags", {14'h0, Done, Busy}, 16'h0000);
        repeat (20) sample();

        // Back-to-back ADDs with Start held high, then MUL launched from DONE
        ALUK = 2'b00; SR2MUX = 1'b0; SR1_OUT = 16'd1; SR2_OUT = 16'd1; Start = 1'b1;
        @(posedge Clk); #2;
        SR1_OUT = 16'd2; SR2_OUT = 16'd2;
        sample();
        chk("b2b_1", {Done, Result[14:0]}, 16'h8002);
        @(posedge Clk); #2;
        SR1_OUT = 16'd3; SR2_OUT = 16'd3;
        sample();
        chk("b2b_2", {Done, Result[14:0]}, 16'h8004);
        @(posedge Clk); #2;
        ALUK = 2'b11; SR1_OUT = 16'h00FF; SR2_OUT = 16'h0101;
        sample();
        chk("b2b_3", {Done, Result[14:0]}, 16'h8006);
        @(posedge Clk); #2;
        Start = 1'b0;
        repeat (18) sample();
        chk("mul_from_done", Result, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port Start, input, 1, launch request sampled on the rising edge of Clk.
REQ-004 SHALL have port ALUK, input, 2, operation select: 00 ADD, 01 AND, 10 NOT, 11 MUL.
REQ-005 SHALL have port SR2MUX, input, 1, operand B select: 0 SR2_OUT, 1 sign-extended imm5.
REQ-006 SHALL have port IMM5, input, 5, immediate field.
REQ-007 SHALL have port SR1_OUT, input, 16, register-file operand A.
REQ-008 SHALL have port SR2_OUT, input, 16, register-file operand B.
REQ-009 SHALL have port Result, output, 16, registered result, driven toward the bus and register-file write port.
REQ-010 SHALL have port Done, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port Busy, output, 1, high while an operation is in flight.
REQ-012 SHALL have port NZP, output, 3, condition code register, {N,Z,P}.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; Busy = (state == CALC).
REQ-014 Start SHALL be accepted only in IDLE or DONE; Start in CALC SHALL be ignored, with no queuing.
REQ-015 On acceptance, SHALL latch A = SR1_OUT, B = SR2MUX ? sign-extended IMM5 : SR2_OUT, and ALUK.
REQ-016 ADD/AND/NOT: Result = A+B mod 2^16, A&B, ~A; acceptance edge goes directly to DONE with Result loaded; Done high in the following cycle (latency 1).
REQ-017 MUL: acceptance edge enters CALC with acc=0 and cnt=0; each CALC cycle, if B[0] then acc += A mod 2^16; A <<= 1; B >>= 1; cnt++.
REQ-018 MUL SHALL leave CALC after the cycle where cnt==15, loading Result = acc and entering DONE; Done high exactly 17 cycles after the acceptance edge.
REQ-019 MUL result SHALL be the low 16 bits of the product; this is the correct two's-complement result for signed operands, and overflow is discarded silently.
REQ-020 Done SHALL be high for exactly the one cycle the FSM is in DONE; without Start, DONE returns to IDLE.
REQ-021 Start in DONE SHALL launch the next operation in that same edge; back-to-back ADDs give Done high on consecutive cycles.
REQ-022 NZP SHALL update only on the edge that loads Result: N=Result[15]; Z=(Result==0); P otherwise; exactly one bit set.
REQ-023 Result and NZP SHALL hold their values between completions.
REQ-024 Changes to SR1_OUT/SR2_OUT/IMM5/ALUK after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-025 Reset low at a rising edge SHALL force state IDLE, Result 16'h0000, NZP 3'b010, Done 0, Busy 0, acc 0, cnt 0.
REQ-026 Reset SHALL take priority over Start.
REQ-027 Reset asserted mid-MUL SHALL abort the operation: no Done pulse, and Result/NZP take their reset values.

Structure
REQ-028 Shared package exec_pkg SHALL hold the ALUK opcode enum, the FSM state enum, and the MUL_CYCLES=16 constant.
REQ-029 SHALL instantiate one combinational sub-module, nzp_calc (16-bit in, 3-bit NZP out); all other logic SHALL be inline.

Verification
REQ-030 ADD, SR2MUX=1, SR1_OUT=16'h0005, IMM5=5'b11101 (-3) -> next cycle Done=1, Result=16'h0002, NZP=001.
REQ-031 AND, SR1_OUT=16'hF0F0, SR2_OUT=16'h0F0F -> Result=16'h0000, NZP=010; then NOT, SR1_OUT=16'h0000 -> Result=16'hFFFF, NZP=100.
REQ-032 MUL, SR1_OUT=16'h0007, SR2_OUT=16'hFFFD -> Busy for 16 cycles, Done 17 cycles after Start, Result=16'hFFEB, NZP=100.
REQ-033 MUL in flight plus Start with ADD at CALC cycle 5 -> the ADD is ignored, and the MUL result is delivered unchanged.
REQ-034 Reset low at MUL CALC cycle 8 -> next cycle IDLE, Result=0, NZP=010, and no Done pulse follows.
REQ-035 Three back-to-back ADDs with Start held high (1+1, 2+2, 3+3) -> Done high three consecutive cycles, with Results 2, 4, 6.
